// File: rtl/wptr_full_level.sv
// Write-side pointer and status block for an asynchronous FIFO.
// Keeps the binary and Gray write pointers and the registered full flag.
// Also provides a write-domain fill level, a programmable almost-full flag,
// a sticky overflow error and a one-cycle write-accept strobe.
// Every status output comes straight from a flop. wptr can therefore cross
// into the read domain without glitches.
module wptr_full_level #(
   parameter int ADDR_SIZE = 4
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 winc,
   input  logic [ADDR_SIZE:0]   wq2_rptr,
   input  logic [ADDR_SIZE:0]   wafull_thresh,
   input  logic                 wovf_clr,
   output logic [ADDR_SIZE-1:0] waddr,
   output logic [ADDR_SIZE:0]   wptr,
   output logic                 wfull,
   output logic                 walmost_full,
   output logic [ADDR_SIZE:0]   wlevel,
   output logic                 wack,
   output logic                 woverflow
);

   // Gray-to-binary: the MSB passes through, and each lower bit folds in the bits above it.
   function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
      logic [ADDR_SIZE:0] b;
      b[ADDR_SIZE] = g[ADDR_SIZE];
      for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
         b[i] = b[i + 1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_SIZE:0] wbin_q,   wbin_d;
   logic [ADDR_SIZE:0] wptr_q,   wptr_d;
   logic [ADDR_SIZE:0] wlevel_q, wlevel_d;
   logic               wfull_q,  wfull_d;
   logic               walmost_full_q, walmost_full_d;
   logic               wack_q,   wack_d;
   logic               woverflow_q, woverflow_d;

   logic               wwrite_s;
   logic [ADDR_SIZE:0] wrbin_s;
   logic [ADDR_SIZE:0] full_cmp_s;

   // Next-state logic for the pointers and for every status flag.
   always_comb begin
      wwrite_s   = winc & ~wfull_q;
      wbin_d     = wbin_q + {{ADDR_SIZE{1'b0}}, wwrite_s};
      wptr_d     = (wbin_d >> 1) ^ wbin_d;
      wrbin_s    = gray2bin(wq2_rptr);
      wlevel_d   = wbin_d - wrbin_s;
      // Full when the next write pointer equals the read pointer with the top two Gray bits inverted.
      full_cmp_s = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
      wfull_d    = (wptr_d == full_cmp_s);
      walmost_full_d = (wlevel_d >= wafull_thresh);
      wack_d     = wwrite_s;
      // If a new overflow and a clear arrive in the same cycle, the new overflow is kept.
      woverflow_d = (woverflow_q & ~wovf_clr) | (winc & wfull_q);
   end

   // State registers; an asynchronous reset clears everything.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q         <= {(ADDR_SIZE+1){1'b0}};
         wptr_q         <= {(ADDR_SIZE+1){1'b0}};
         wlevel_q       <= {(ADDR_SIZE+1){1'b0}};
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         wack_q         <= 1'b0;
         woverflow_q    <= 1'b0;
      end else begin
         wbin_q         <= wbin_d;
         wptr_q         <= wptr_d;
         wlevel_q       <= wlevel_d;
         wfull_q        <= wfull_d;
         walmost_full_q <= walmost_full_d;
         wack_q         <= wack_d;
         woverflow_q    <= woverflow_d;
      end
   end

   assign waddr        = wbin_q[ADDR_SIZE-1:0];
   assign wptr         = wptr_q;
   assign wfull        = wfull_q;
   assign walmost_full = walmost_full_q;
   assign wlevel       = wlevel_q;
   assign wack         = wack_q;
   assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Self-checking bench for wptr_full_level.
// The reference model tracks plain integer counts of writes and reads.
// Stimulus combines directed table rows, hand sequences and random traffic.
module tb_wptr_full_level;
   localparam int AS    = 4;
   localparam int DEPTH = 1 << AS;

   logic          wclk = 1'b0;
   logic          wrst_n;
   logic          winc;
   logic [AS:0]   wq2_rptr;
   logic [AS:0]   wafull_thresh;
   logic          wovf_clr;
   logic [AS-1:0] waddr;
   logic [AS:0]   wptr;
   logic          wfull;
   logic          walmost_full;
   logic [AS:0]   wlevel;
   logic          wack;
   logic          woverflow;

   wptr_full_level #(.ADDR_SIZE(AS)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
      .wafull_thresh(wafull_thresh), .wovf_clr(wovf_clr), .waddr(waddr),
      .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
      .wlevel(wlevel), .wack(wack), .woverflow(woverflow)
   );

   // Free-running write clock.
   always #5 wclk = ~wclk;

   int checks = 0;
   int errors = 0;

   // Reference model: total accepted writes and total visible reads.
   int m_wcnt;
   int m_rd;
   int m_level;
   bit m_full, m_almost, m_ack, m_ovf;

   typedef struct {
      bit inc; int rd; int th; bit clr;
      int e_addr; int e_ptr; int e_level;
      bit e_full; bit e_alm; bit e_ack; bit e_ovf;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [AS:0] gray(input int n);
      logic [AS:0] b;
      b = AS'(0);
      b = n[AS:0];
      return b ^ (b >> 1);
   endfunction

   function automatic vec_t mk(bit inc, int rd, int th, bit clr, int a, int p,
                               int l, bit f, bit al, bit ak, bit ov);
      vec_t v;
      v.inc = inc; v.rd = rd; v.th = th; v.clr = clr;
      v.e_addr = a; v.e_ptr = p; v.e_level = l;
      v.e_full = f; v.e_alm = al; v.e_ack = ak; v.e_ovf = ov;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wcnt = 0; m_rd = 0; m_level = 0;
      m_full = 1'b0; m_almost = 1'b0; m_ack = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic check_model();
      chk("waddr",  32'(waddr),        32'(m_wcnt % DEPTH));
      chk("wptr",   32'(wptr),         32'(gray(m_wcnt % (2 * DEPTH))));
      chk("wlevel", 32'(wlevel),       32'(m_level));
      chk("wfull",  32'(wfull),        32'(m_full));
      chk("walmost_full", 32'(walmost_full), 32'(m_almost));
      chk("wack",   32'(wack),         32'(m_ack));
      chk("woverflow", 32'(woverflow), 32'(m_ovf));
      chk("full_eq_level", 32'(wfull), 32'(wlevel == (AS+1)'(DEPTH)));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_waddr"},  32'(waddr),  32'd0);
      chk({tag, "_wptr"},   32'(wptr),   32'd0);
      chk({tag, "_wlevel"}, 32'(wlevel), 32'd0);
      chk({tag, "_wfull"},  32'(wfull),  32'd0);
      chk({tag, "_walm"},   32'(walmost_full), 32'd0);
      chk({tag, "_wack"},   32'(wack),   32'd0);
      chk({tag, "_wovf"},   32'(woverflow), 32'd0);
   endtask

   // One clock: drive the inputs, step the model, then sample 1 ns after the edge.
   task automatic cycle(input bit inc, input int rd, input int th, input bit clr);
      bit wr;
      winc = inc; wq2_rptr = gray(rd % (2 * DEPTH));
      wafull_thresh = th[AS:0]; wovf_clr = clr;
      wr       = inc && !m_full;
      m_ovf    = (m_ovf && !clr) || (inc && m_full);
      m_wcnt   = m_wcnt + (wr ? 1 : 0);
      m_rd     = rd;
      m_level  = m_wcnt - rd;
      m_full   = (m_level == DEPTH);
      m_almost = (m_level >= th);
      m_ack    = wr;
      @(posedge wclk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; wovf_clr = 1'b0;
      #1;
      check_zero("rst");
      model_reset();
      @(posedge wclk);
      @(negedge wclk);
      wrst_n = 1'b1;
   endtask

   initial begin
      logic [AS:0] prev_ptr;
      int rd;
      int th;
      wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; wafull_thresh = 5'd12; wovf_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge wclk);
      #1;
      check_zero("por");
      @(negedge wclk);
      wrst_n = 1'b1;

      // Directed table: fill, overflow, clear, then drain a few entries.
      for (int i = 0; i < 16; i++)
         tbl.push_back(mk(1'b1, 0, 12, 1'b0, (i + 1) % 16, int'(gray(i + 1)), i + 1,
                          i == 15, (i + 1) >= 12, 1'b1, 1'b0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1'b1, 0, 12, 1'b0, 0, 24, 16, 1'b1, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 0, 12, 1'b1, 0, 24, 16, 1'b1, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 0, 12, 1'b1, 0, 24, 16, 1'b1, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 1, 12, 1'b0, 0, 24, 15, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 2, 12, 1'b0, 0, 24, 14, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 3, 12, 1'b0, 0, 24, 13, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 4, 12, 1'b0, 0, 24, 12, 1'b0, 1'b1, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 5, 12, 1'b0, 0, 24, 11, 1'b0, 1'b0, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 6, 12, 1'b0, 0, 24, 10, 1'b0, 1'b0, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 7, 12, 1'b0, 0, 24,  9, 1'b0, 1'b0, 1'b0, 1'b1));
      foreach (tbl[k]) begin
         cycle(tbl[k].inc, tbl[k].rd, tbl[k].th, tbl[k].clr);
         chk("tbl_waddr",  32'(waddr),  32'(tbl[k].e_addr));
         chk("tbl_wptr",   32'(wptr),   32'(tbl[k].e_ptr));
         chk("tbl_wlevel", 32'(wlevel), 32'(tbl[k].e_level));
         chk("tbl_wfull",  32'(wfull),  32'(tbl[k].e_full));
         chk("tbl_walm",   32'(walmost_full), 32'(tbl[k].e_alm));
         chk("tbl_wack",   32'(wack),   32'(tbl[k].e_ack));
         chk("tbl_wovf",   32'(woverflow), 32'(tbl[k].e_ovf));
      end

      // Reset mid-operation at level 9 with overflow set; the next write lands at address 0.
      do_reset();
      cycle(1'b1, 0, 12, 1'b0);
      chk("post_rst_waddr",  32'(waddr),  32'd1);
      chk("post_rst_wlevel", 32'(wlevel), 32'd1);

      // With threshold 0, almost-full is set right after the first edge out of reset.
      do_reset();
      cycle(1'b0, 0, 0, 1'b0);
      chk("thresh0_walm", 32'(walmost_full), 32'd1);

      // Steady stream at constant level 5 across the pointer wrap.
      for (int i = 0; i < 5; i++) cycle(1'b1, 0, 12, 1'b0);
      rd = 0;
      for (int i = 0; i < 45; i++) begin
         prev_ptr = wptr;
         rd++;
         cycle(1'b1, rd, 12, 1'b0);
         chk("stream_level", 32'(wlevel), 32'd5);
         chk("stream_onebit", 32'($countones(prev_ptr ^ wptr)), 32'd1);
         chk("stream_nofull", 32'(wfull), 32'd0);
      end

      // Random traffic: threshold 16 first, then random quasi-static thresholds.
      do_reset();
      rd = 0;
      th = 16;
      for (int i = 0; i < 600; i++) begin
         if (i >= 300 && (i % 50) == 0) th = int'($urandom_range(0, DEPTH));
         if (rd < m_wcnt && ($urandom % 3) != 0) rd++;
         cycle(($urandom % 10) < 7, rd, th, ($urandom % 10) == 0);
         if (th == DEPTH) chk("thresh16_alm_eq_full", 32'(walmost_full), 32'(wfull));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
